// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words and writes them to consecutive word addresses from 0. The CPU is
// held in reset (cpu_hold) while a load is in progress.
module imem_loader #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [31:0] BASE_PC = 32'h00003000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_base
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    // Largest legal length: a full memory of 2^ADDR_W words.
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] OneW   = {{ADDR_W{1'b0}}, 1'b1};

    state_e          state_q;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] idx_q;
    logic [1:0]      cnt_q;
    logic [23:0]     shift_q;   // first three bytes of the word being assembled
    logic [ADDR_W:0] idx_next;

    assign idx_next  = idx_q + OneW;
    assign load_base = BASE_PC;

    // Loader FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            in_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            we   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Start has priority over a coincident abort, which is ignored here.
                    if (start) begin
                        if (len_words == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else if (len_words > MaxLen) begin
                            err <= 1'b1;
                        end else begin
                            len_q    <= len_words;
                            idx_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= StRecv;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    if (abort) begin
                        // Partial word is dropped.
                        state_q  <= StIdle;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        shift_q <= {shift_q[15:0], in_byte};
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            wdata    <= {shift_q, in_byte};
                            waddr    <= idx_q[ADDR_W-1:0];
                            we       <= 1'b1;
                            in_ready <= 1'b0;
                            state_q  <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    // The write itself has already been presented this cycle.
                    idx_q <= idx_next;
                    cnt_q <= '0;
                    if (abort) begin
                        state_q  <= StIdle;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (idx_next == len_q) begin
                        state_q  <= StDone;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else begin
                        state_q  <= StRecv;
                        in_ready <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes
// and done/err pulses into a queue; a negedge monitor pops and compares.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   len_words;
    logic          abort;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [31:0]   load_base;

    imem_loader #(.ADDR_W(AW), .BASE_PC(32'h00003000)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len_words (len_words),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .load_base (load_base)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] KWr = 2'd1, KDone = 2'd2, KErr = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] stim[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: every we/done/err pulse must match the head of the queue.
    ev_t got_ev, exp_ev;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (we || done || err) begin
                got_ev.kind = we ? KWr : (done ? KDone : KErr);
                got_ev.addr = we ? waddr : '0;
                got_ev.data = we ? wdata : '0;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got kind=%0d addr=%0d data=0x%08h, none expected",
                             got_ev.kind, got_ev.addr, got_ev.data);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (got_ev !== exp_ev) begin
                        n_err++;
                        $display("FAIL event: got kind=%0d addr=%0d data=0x%08h expected kind=%0d addr=%0d data=0x%08h",
                                 got_ev.kind, got_ev.addr, got_ev.data,
                                 exp_ev.kind, exp_ev.addr, exp_ev.data);
                    end
                end
            end
            if (we) chk("in_ready_during_write", {31'd0, in_ready}, 32'd0);
            if (done) chk("busy_at_done", {30'd0, busy, cpu_hold}, 32'd0);
            if (cpu_hold !== busy) chk("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int bound;
        repeat ($urandom_range(maxgap, 0)) cyc();
        in_valid = 1'b1;
        in_byte  = b;
        bound    = 0;
        while (in_ready !== 1'b1 && bound < 20) begin
            cyc();
            bound++;
        end
        if (bound >= 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int bound = 0;
        while (exp_q.size() != 0 && bound < 60) begin
            cyc();
            bound++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic fill(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        len_words = (AW+1)'(len);
        cyc();
        start = 1'b0;
    endtask

    // Reference: word i is bytes 4i..4i+3 big-endian, written to address i;
    // done follows only a complete, un-aborted load.
    task automatic run_load(input int len, input int nbytes, input int maxgap,
                            input int poke_at, input bit do_abort);
        int   nw;
        ev_t  e;
        if (len == 0) begin
            e = '{kind: KDone, addr: '0, data: '0};
            exp_q.push_back(e);
        end else if (len > (1 << AW)) begin
            e = '{kind: KErr, addr: '0, data: '0};
            exp_q.push_back(e);
        end else begin
            nw = nbytes / 4;
            if (nw > len) nw = len;
            for (int i = 0; i < nw; i++) begin
                e.kind = KWr;
                e.addr = AW'(i);
                e.data = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
                exp_q.push_back(e);
            end
            if (!do_abort && nbytes >= 4 * len) begin
                e = '{kind: KDone, addr: '0, data: '0};
                exp_q.push_back(e);
            end
        end
        pulse_start(len);
        if (len == 0) begin
            chk("len0_done", {31'd0, done}, 32'd1);
            chk("len0_busy", {31'd0, busy}, 32'd0);
        end else if (len > (1 << AW)) begin
            chk("oversize_err", {31'd0, err}, 32'd1);
            chk("oversize_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("hold_after_start", {30'd0, busy, cpu_hold}, 32'd3);
        end
        for (int i = 0; i < nbytes; i++) begin
            if (i == poke_at) pulse_start(1);
            send_byte(stim[i], maxgap);
        end
        if (do_abort) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk("abort_idle", {30'd0, busy, in_ready}, 32'd0);
        end
        drain();
        repeat (3) cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_waddr"}, {22'd0, waddr}, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
    endtask

    task automatic single_word();
        stim = '{8'h3C, 8'h01, 8'h12, 8'h34};
        run_load(1, 4, 0, -1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len_words = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = '0;
        repeat (3) cyc();
        check_reset_outputs("reset");
        chk("load_base", load_base, 32'h00003000);
        reset = 1'b0;
        cyc();

        single_word();

        fill(12);
        run_load(3, 12, 3, -1, 1'b0);

        run_load(0, 0, 0, -1, 1'b0);
        run_load(1025, 0, 0, -1, 1'b0);
        fill(4096);
        run_load(1024, 4096, 0, -1, 1'b0);

        // Abort in the middle of word 1, then a clean reload.
        fill(6);
        run_load(2, 6, 1, -1, 1'b1);
        single_word();

        // Reset after six bytes, then a clean reload.
        fill(6);
        run_load(3, 6, 0, -1, 1'b0);
        reset = 1'b1;
        cyc();
        check_reset_outputs("midreset");
        reset = 1'b0;
        cyc();
        single_word();

        // Start during RECV must not shorten the load.
        fill(12);
        run_load(3, 12, 1, 5, 1'b0);

        for (int k = 0; k < 10; k++) begin
            int len;
            len = $urandom_range(6, 1);
            fill(4 * len);
            run_load(len, 4 * len, $urandom_range(2, 0), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream and writes it word by word into the instruction memory that the fetch unit reads.
- Holds the CPU in reset while loading, so fetch restarts from the base PC 0x00003000 once the load finishes.
- Sits between the host/debug byte channel and the instruction-memory write port.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (1024 words).
- BASE_PC, 32'h00003000, byte address of word 0; reported on load_base.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- len_words  in  ADDR_W+1  number of words to load; latched on accepted start.
- abort  in  1  cancel an in-progress load.
- in_valid  in  1  byte-stream valid.
- in_byte  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- we  out  1  instruction-memory write enable (one cycle per word).
- waddr  out  ADDR_W  instruction-memory word address.
- wdata  out  32  instruction word.
- busy  out  1  high in RECV or WRITE.
- cpu_hold  out  1  equals busy; drives the CPU reset request.
- done  out  1  one-cycle pulse after the final word is written.
- err  out  1  one-cycle pulse when start is rejected for an oversize length.
- load_base  out  32  constant BASE_PC.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready, we, busy, cpu_hold, done, err = 0.
  - waddr = 0, wdata = 0.
  - Word index, byte count and the latched length are all cleared.
- State IDLE:
  - start=1 and len_words = 0 → DONE (no writes).
  - start=1 and len_words > 2^ADDR_W → err pulse next cycle; remain IDLE.
  - start=1 otherwise → latch the length, clear the index and byte count, go to RECV.
- State RECV:
  - in_ready=1.
  - Each cycle with in_valid & in_ready: shift_reg = {shift_reg[23:0], in_byte} and the byte count increments. This is big-endian: the first byte becomes bits 31:24.
  - On the 4th accepted byte: wdata <= the assembled word, waddr <= index, go to WRITE.
  - in_valid low: hold with no state change. There is no timeout.
- State WRITE:
  - Lasts exactly one cycle: we=1, in_ready=0.
  - Next cycle: index+1, byte count cleared.
  - If index+1 == latched length → DONE; else → RECV.
- State DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - The CPU is released (cpu_hold falls) on the same edge as done rises.
- Throughput: at best 5 cycles per word (4 bytes, then 1 write cycle).
- we is never asserted outside WRITE. waddr and wdata are stable whenever we=1.
- Index width: ADDR_W+1 bits; the length compare uses the full width. len = 1024 fills addresses 0..1023 with no wrap.
- abort:
  - Effective in RECV or WRITE: next state IDLE, no done pulse.
  - A WRITE in progress on the abort cycle still completes its single we cycle.
  - A partial word is discarded.
  - Ignored in IDLE and DONE.
- start while busy or in DONE: ignored.
- Simultaneous start and abort in IDLE: start wins.
- reset mid-operation: returns to reset values on the next edge; the partial word and index are lost, and no done or err pulse is produced.
- Memory contents already written are not cleared by the loader.

Test Plan:
- Single word:
  - Stimulus: start, len=1; bytes 0x3C,0x01,0x12,0x34 with in_valid held high.
  - Required: we=1 exactly once, waddr=0, wdata=0x3C011234; done pulses the following cycle; cpu_hold high from the cycle after start until done.
- Three words with in_valid gaps:
  - Stimulus: 12 bytes delivered with random idle cycles between them.
  - Required: writes to waddr 0,1,2 with the correct big-endian words; byte count unaffected by idle cycles; in_ready=0 during each WRITE cycle.
- Boundary lengths:
  - len=0 → done after 1 cycle, no we.
  - len=1024 → last write at waddr=1023, then done.
  - len=1025 → err pulse, busy stays 0.
- Abort mid-word:
  - Stimulus: len=2; word 0 completes, then 2 bytes of word 1 are sent before abort.
  - Required: one write only; no done; IDLE.
  - A new start, len=1 then loads waddr 0 cleanly.
- Reset mid-load:
  - Stimulus: reset asserted after 6 bytes.
  - Required: all outputs at reset values next cycle.
  - A subsequent load behaves as the single-word case.
- Ignored start:
  - Stimulus: start pulsed during RECV.
  - Required: latched length unchanged; load completes with the original count.
